// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled) feeding a first-word-fall-through receive FIFO.
// Optional parity checking is compiled in when UART_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_16x,
  input  logic                       rxd,
  input  logic                       rd_rx,
  input  logic                       clr_err,
  output logic [DATA_BITS-1:0]       rx_data,
  output logic                       rda,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       frame_err,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state_reg, state_next;
  logic [3:0]           tick_reg, tick_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 rxd_meta_reg, rxd_s_reg;
  logic                 frame_done;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg, count_next;
  logic                 frame_err_reg, overrun_reg;
  logic                 stop_bad, par_bad, push_ok, push, pop, full;

`ifdef UART_PARITY_EN
  logic par_bit_reg, par_bit_next;
  logic parity_err_reg;
`endif

  // Receive FSM: all sampling happens on en_16x ticks only.
  always_comb begin
    state_next   = state_reg;
    tick_next    = tick_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    frame_done   = 1'b0;
`ifdef UART_PARITY_EN
    par_bit_next = par_bit_reg;
`endif
    if (en_16x) begin
      case (state_reg)
        S_IDLE: begin
          if (!rxd_s_reg) begin
            state_next = S_START;
            tick_next  = 4'd0;
          end
        end
        S_START: begin
          if (tick_reg == 4'd7) begin
            tick_next    = 4'd0;
            bit_cnt_next = 4'd0;
            state_next   = rxd_s_reg ? S_IDLE : S_DATA;
          end else begin
            tick_next = tick_reg + 4'd1;
          end
        end
        S_DATA: begin
          tick_next = tick_reg + 4'd1;
          if (tick_reg == 4'd15) begin
            shift_next = {rxd_s_reg, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == 4'(DATA_BITS-1)) begin
`ifdef UART_PARITY_EN
              state_next = S_PARITY;
`else
              state_next = S_STOP;
`endif
            end else begin
              bit_cnt_next = bit_cnt_reg + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          tick_next = tick_reg + 4'd1;
          if (tick_reg == 4'd15) begin
            par_bit_next = rxd_s_reg;
            state_next   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          tick_next = tick_reg + 4'd1;
          if (tick_reg == 4'd15) begin
            frame_done = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Frame verdict is taken on the stop-bit sample; framing error has priority.
  always_comb begin
    stop_bad = frame_done && !rxd_s_reg;
`ifdef UART_PARITY_EN
    par_bad  = frame_done && rxd_s_reg &&
               (par_bit_reg != ((^shift_reg) ^ 1'(PARITY_ODD)));
`else
    par_bad  = 1'b0;
`endif
    push_ok  = frame_done && rxd_s_reg && !par_bad;
    full     = (count_reg == CW'(DEPTH));
    pop      = rd_rx && (count_reg != '0);
    push     = push_ok && (!full || pop);
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_meta_reg   <= 1'b1;
      rxd_s_reg      <= 1'b1;
      state_reg      <= S_IDLE;
      tick_reg       <= 4'd0;
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      rxd_meta_reg   <= rxd;
      rxd_s_reg      <= rxd_meta_reg;
      state_reg      <= state_next;
      tick_reg       <= tick_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      count_reg      <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      // A new error in the same cycle as clr_err leaves the flag set.
      frame_err_reg  <= (frame_err_reg && !clr_err) || stop_bad;
      overrun_reg    <= (overrun_reg && !clr_err) || (push_ok && full && !pop);
`ifdef UART_PARITY_EN
      par_bit_reg    <= par_bit_next;
      parity_err_reg <= (parity_err_reg && !clr_err) || par_bad;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= shift_reg;
  end

  assign rda        = (count_reg != '0);
  assign rx_data    = rda ? mem[rd_ptr_reg] : '0;
  assign fifo_count = count_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
`ifdef UART_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level queue model, directed cases plus random frames.
// Parity frames are generated when UART_PARITY_EN is defined.
module tb_uart_rx_fifo;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int PODD  = 0;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB     = DB + 2 + PAR;
  // negedge index (within a frame) just before the edge that samples mid-stop
  localparam int STOP_E = 16 * (NB - 1) + 10;

  logic          clk = 1'b0;
  logic          rst_n, en_16x, rxd, rd_rx, clr_err;
  logic [DB-1:0] rx_data;
  logic          rda, frame_err, overrun, parity_err;
  logic [2:0]    fifo_count;

  uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst_n(rst_n), .en_16x(en_16x), .rxd(rxd), .rd_rx(rd_rx),
    .clr_err(clr_err), .rx_data(rx_data), .rda(rda), .fifo_count(fifo_count),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DB-1:0] q[$];
  bit fe_m, ov_m, pe_m;
  logic rda_pre, rda_post;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [DB-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    check({tag, "_rda"}, 32'(rda), 32'(q.size() > 0));
    check({tag, "_data"}, 32'(rx_data), 32'(head));
    check({tag, "_ferr"}, 32'(frame_err), 32'(fe_m));
    check({tag, "_ovr"}, 32'(overrun), 32'(ov_m));
    check({tag, "_perr"}, 32'(parity_err), 32'(pe_m));
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One frame, bit by bit; optional one-clk pop / clr_err at chosen negedge indices.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_b, input bit par_flip,
                            input int pop_k, input int clr_k);
    logic [NB-1:0] bits;
    logic [DB-1:0] head_obs;
    bit popped;
    head_obs = '0;
    popped   = 1'b0;
    bits = '0;
    bits[DB:1] = d;
`ifdef UART_PARITY_EN
    bits[DB+1] = (^d) ^ 1'(PODD) ^ par_flip;
`endif
    bits[NB-1] = stop_b;
    for (int k = 0; k < 16 * NB; k++) begin
      @(negedge clk);
      if (k == STOP_E)     rda_pre  = rda;
      if (k == STOP_E + 1) rda_post = rda;
      if (k == pop_k) begin
        head_obs = rx_data;
        popped   = rda;
        rd_rx    = 1'b1;
      end else begin
        rd_rx = 1'b0;
      end
      clr_err = (k == clr_k);
      rxd = bits[k/16];
    end
    @(negedge clk);
    rxd = 1'b1; rd_rx = 1'b0; clr_err = 1'b0;
    if (pop_k >= 0 && q.size() > 0) begin
      check("frame_pop_head", 32'(head_obs), 32'(q[0]));
      void'(q.pop_front());
    end else if (pop_k >= 0) begin
      check("frame_pop_empty", 32'(popped), 32'(0));
    end
    if (clr_k >= 0) begin fe_m = 0; ov_m = 0; pe_m = 0; end
    if (!stop_b)                 fe_m = 1;
    else if (PAR != 0 && par_flip) pe_m = 1;
    else if (q.size() == DEPTH)  ov_m = 1;
    else                         q.push_back(d);
    $display("frame data=%02h stop=%0d pflip=%0d pop_k=%0d -> count=%0d rda=%0d ferr=%0d ovr=%0d perr=%0d",
             d, stop_b, par_flip, pop_k, fifo_count, rda, frame_err, overrun, parity_err);
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk);
    check({tag, "_pophead"}, 32'(rx_data), 32'((q.size() > 0) ? q[0] : '0));
    rd_rx = 1'b1;
    @(negedge clk);
    rd_rx = 1'b0;
    $display("pop data=%02h", rx_data);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    fe_m = 0; ov_m = 0; pe_m = 0;
    $display("clr_err");
  endtask

  initial begin
    rst_n = 1'b0; en_16x = 1'b1; rxd = 1'b1; rd_rx = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_outputs("reset");

    // basic frame, push latency and pop
    idle(20);
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    check("lat_before", 32'(rda_pre), 32'(0));
    check("lat_after", 32'(rda_post), 32'(1));
    check_outputs("t1");
    pop_one("t1");
    check_outputs("t1_empty");

    // false start glitch
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check_outputs("glitch");
    send_frame(8'hC3, 1'b1, 1'b0, -1, -1);
    check_outputs("post_glitch");
    pop_one("post_glitch");

    // framing error and clear
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    idle(32);
    check_outputs("ferr");
    do_clr();
    check_outputs("ferr_clr");

    // back-to-back frames overflowing the FIFO
    for (int i = 0; i < 5; i++) send_frame(DB'(i), 1'b1, 1'b0, -1, -1);
    idle(32);
    check_outputs("ovr");
    for (int i = 0; i < 4; i++) pop_one("drain");
    check_outputs("drained");
    do_clr();

    // full FIFO with push and pop on the same edge: no overrun
    for (int i = 0; i < 4; i++) send_frame(8'h40 + DB'(i), 1'b1, 1'b0, -1, -1);
    send_frame(8'h77, 1'b1, 1'b0, STOP_E, -1);
    idle(20);
    check_outputs("full_pushpop");

    // clr_err on the same edge as a new framing error: error wins
    send_frame(8'h99, 1'b0, 1'b0, -1, STOP_E);
    idle(32);
    check_outputs("clr_vs_err");
    while (q.size() > 0) pop_one("flush");
    do_clr();

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    idle(20);
    check_outputs("par_bad");
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    idle(20);
    check_outputs("par_good");
    pop_one("par");
    do_clr();
`endif

    // random frames against the queue model
    for (int it = 0; it < 40; it++) begin
      logic [DB-1:0] d;
      bit sb, pf;
      int pk;
      d  = DB'($urandom);
      sb = ($urandom_range(7) != 0);
      pf = (PAR != 0) && ($urandom_range(7) == 0);
      pk = ($urandom_range(3) == 0) ? STOP_E : -1;
      send_frame(d, sb, pf, pk, -1);
      idle(sb ? $urandom_range(20) : 24);
      check_outputs("rand");
      for (int p = $urandom_range(2); p > 0; p--)
        if (q.size() > 0) pop_one("rand");
      if ($urandom_range(5) == 0) do_clr();
    end

    // reset in the middle of a frame, with state to lose
    while (q.size() > 0) pop_one("pre_rst");
    send_frame(8'h11, 1'b1, 1'b0, -1, -1);
    send_frame(8'h22, 1'b0, 1'b0, -1, -1);
    idle(24);
    check_outputs("pre_rst");
    for (int k = 0; k < 16 * 4; k++) begin
      @(negedge clk);
      rxd = (k < 16) ? 1'b0 : 1'b1 ^ k[4];
    end
    @(negedge clk);
    rst_n = 1'b0; rxd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete(); fe_m = 0; ov_m = 0; pe_m = 0;
    $display("reset mid-frame");
    check_outputs("rst_mid");
    idle(40);
    check_outputs("rst_idle");
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
    check_outputs("after_rst");
    pop_one("after_rst");
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
